// File: rtl/pixel_fb_writer.sv
// Pixel framebuffer writer.
// Buffers per-cycle pixel writes from the drawing stage, drops off-screen pixels,
// converts (X, Y) to a linear address and drives the framebuffer write port,
// yielding to the scan-out reader while fb_busy is high.
module pixel_fb_writer #(
    parameter int unsigned WIDTH  = 160,
    parameter int unsigned HEIGHT = 120,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        CounterX,
    input  logic [7:0]        CounterY,
    input  logic [11:0]       color,
    input  logic              fb_busy,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_data,
    output logic [15:0]       drop_count,
    output logic              idle
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EntW = ADDR_W + 12;

    typedef enum logic [0:0] {
        StIdle,
        StWrite
    } state_e;

    // FIFO storage and bookkeeping; an entry is {addr, colour}
    logic [EntW-1:0]   mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW:0]     count_q;

    state_e            state_q;
    logic              fb_we_q;

    logic              full;
    logic              empty;
    logic              in_range;
    logic              accept;
    logic              push;
    logic              drop;
    logic              pop;
    logic [ADDR_W-1:0] pix_addr;
    logic [EntW-1:0]   head;

    assign full     = (count_q == (PtrW + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_range = (32'(CounterX) < WIDTH) && (32'(CounterY) < HEIGHT);

    // in_ready looks only at FIFO occupancy, never at in_valid
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && in_range;
    assign drop     = accept && !in_range;

    // Pop only from registered occupancy, so a same-cycle push is never forwarded
    assign pop      = !empty && !fb_busy;
    assign head     = mem_q[rd_ptr_q];

    // Linear address: 160 = 128 + 32, so the default geometry needs only shift-add
    generate
        if (WIDTH == 160) begin : g_shift_add
            assign pix_addr = (ADDR_W'(CounterY) << 7) + (ADDR_W'(CounterY) << 5)
                            + ADDR_W'(CounterX);
        end else begin : g_mult
            assign pix_addr = ADDR_W'(32'(CounterY) * WIDTH + 32'(CounterX));
        end
    endgenerate

    // FIFO data array; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {pix_addr, color};
        end
    end

    // FIFO pointers and occupancy; reset discards everything buffered
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Write FSM: each pop becomes a one-cycle fb_we on the next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            fb_we_q <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q <= StWrite;
                        fb_we_q <= 1'b1;
                        fb_addr <= head[EntW-1:12];
                        fb_data <= head[11:0];
                    end else begin
                        fb_we_q <= 1'b0;
                    end
                end
                StWrite: begin
                    if (pop) begin
                        // Back-to-back: stay in StWrite and reload
                        state_q <= StWrite;
                        fb_we_q <= 1'b1;
                        fb_addr <= head[EntW-1:12];
                        fb_data <= head[11:0];
                    end else begin
                        state_q <= StIdle;
                        fb_we_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    fb_we_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of off-screen pixels that were accepted and discarded
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    // A write in flight when reset arrives must not reach the RAM in the reset cycle
    assign fb_we = fb_we_q && !reset;
    assign idle  = empty && !fb_we;

endmodule

// File: doc/pixel_fb_writer.md
Name: pixel_fb_writer

Overview:
- Sits directly downstream of the drawing/state stage, which emits one pixel write per cycle as (X, Y, 12-bit colour).
- Buffers these writes in a small FIFO, bounds-checks them, and converts each to a linear framebuffer address (Y*WIDTH + X).
- Drives the single write port of the 160x120 12-bit framebuffer RAM.
- Yields the RAM to the scan-out reader whenever it asserts fb_busy.

Parameters:
- WIDTH, 160, visible pixels per line.
- HEIGHT, 120, visible lines.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 15, framebuffer address width; must hold WIDTH*HEIGHT-1 = 19199.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a pixel write is presented.
- in_ready  output  1  FIFO can accept a write this cycle.
- CounterX  input  8  pixel X coordinate.
- CounterY  input  8  pixel Y coordinate.
- color  input  12  pixel colour, {R[3:0], G[3:0], B[3:0]}.
- fb_busy  input  1  scan-out owns the RAM this cycle; no write may issue.
- fb_we  output  1  framebuffer write strobe.
- fb_addr  output  ADDR_W  framebuffer write address.
- fb_data  output  12  framebuffer write data.
- drop_count  output  16  count of out-of-range writes discarded; saturates at 0xFFFF.
- idle  output  1  FIFO empty and no write in flight.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: FIFO empty, in_ready=1, fb_we=0, fb_addr=0, fb_data=0, drop_count=0, idle=1.
- Reset mid-operation: all buffered pixels are discarded on the reset edge. No fb_we is issued in the reset cycle or in the cycle after reset.
- Input handshake: a write is accepted on the edge where in_valid && in_ready.
  - in_ready = !full, combinational from FIFO state only; it must not depend on in_valid.
  - Upstream holds CounterX, CounterY and color stable while in_valid && !in_ready.
- Bounds check at accept time:
  - A pixel with CounterX >= WIDTH or CounterY >= HEIGHT is accepted (consumes the handshake) but not stored.
  - drop_count increments by 1 for each such pixel, saturating at 0xFFFF.
  - Out-of-range pixels never reach the RAM.
- FIFO:
  - DEPTH entries; each stores {addr, colour}.
  - The address is computed before storing: Y*WIDTH + X, implemented as (Y<<7)+(Y<<5)+X for WIDTH=160, result ADDR_W bits.
  - Simultaneous push and pop when full: pop frees a slot, but in_ready is still 0 that cycle because it is registered from full. No overflow is possible.
  - Simultaneous push and pop when empty: the pushed entry is not forwarded to the RAM in the same cycle. FIFO-to-RAM latency is at least 1 cycle.
- Write state machine, states IDLE and WRITE:
  - IDLE: if FIFO non-empty and !fb_busy, pop the head and go to WRITE. Next cycle: fb_we=1, fb_addr and fb_data = popped entry.
  - WRITE: fb_we held for exactly one cycle.
    - If FIFO still non-empty and !fb_busy, pop the next entry and stay in WRITE, giving back-to-back writes at 1 per cycle.
    - Otherwise go to IDLE with fb_we=0.
  - fb_busy sampled high: no pop that cycle, and no fb_we the following cycle. fb_addr and fb_data hold their last values while fb_we=0.
- Latency: accept at edge N with FIFO empty and fb_busy low gives fb_we=1 during cycle N+2 (push, pop, write).
- Ordering: RAM writes occur in acceptance order. Duplicate addresses are written twice; the last one wins.
- idle = FIFO empty && fb_we==0.

Test Plan:
- Reset, then a single write X=5, Y=2, color=0xF00 -> fb_we for one cycle at N+2 with fb_addr=325, fb_data=0xF00. idle returns to 1 on the next cycle.
- Full-frame sweep X 0..159, Y 0..119, in_valid constant, fb_busy=0 -> exactly 19200 fb_we pulses, addresses 0..19199 in order, in_ready never low for more than 1 cycle, drop_count=0.
- fb_busy high for 10 cycles while 8 pixels are offered -> in_ready falls after DEPTH accepts and no fb_we during busy. After busy falls, all 8 are written in order with no loss or duplication.
- Out-of-range writes (X=160,Y=0), (X=0,Y=120), (X=255,Y=255) interleaved with valid ones -> drop_count=3 and only the valid addresses are written. Force 65540 drops -> drop_count=0xFFFF.
- Reset asserted with 3 entries buffered and one write in flight -> no fb_we on the reset cycle or the cycle after, FIFO empty, drop_count=0.
- Corner pixel X=159, Y=119, color=0xABC -> fb_addr=19199, fb_data=0xABC.
